// File: rtl/spi_stage_seq.sv
// Sequences N_STAGES SPI engines onto one panel bus: start pulse, run until done, gap, next stage.
// Optional per-stage watchdog enabled by defining SPI_STAGE_SEQ_WATCHDOG_EN (default: absent, o_err tied 0).
module spi_stage_seq #(
  parameter int N_STAGES  = 3,
  parameter int START_GAP = 16,
  parameter int LOOP      = 0,
  parameter int LOOP_FROM = 1,
  parameter int TIMEOUT   = 27_000_000,
  localparam int IW = ($clog2(N_STAGES) > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_trig,
  input  logic [N_STAGES-1:0] i_stage_mosi,
  input  logic [N_STAGES-1:0] i_stage_dc,
  input  logic [N_STAGES-1:0] i_stage_cs,
  input  logic [N_STAGES-1:0] i_stage_done,
  output logic [N_STAGES-1:0] o_stage_start,
  output logic                o_mosi,
  output logic                o_dc,
  output logic                o_cs,
  output logic [IW-1:0]       o_stage,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  typedef enum logic [2:0] {ST_START, ST_RUN, ST_GAP, ST_FIN, ST_ERR} state_t;

  localparam logic [IW-1:0]       LAST_IDX  = IW'(N_STAGES - 1);
  localparam logic [IW-1:0]       LOOP_IDX  = IW'(LOOP_FROM);
  localparam logic [15:0]         GAP_LAST  = (START_GAP > 0) ? 16'(START_GAP - 1) : 16'd0;
  localparam logic [N_STAGES-1:0] START_ONE = N_STAGES'(1);
  localparam state_t              AFTER_RUN = (START_GAP == 0) ? ST_START : ST_GAP;

  if (N_STAGES < 2 || N_STAGES > 8) begin : g_bad_n_stages
    $error("N_STAGES out of range");
  end
  if (LOOP_FROM < 1 || LOOP_FROM > N_STAGES - 1) begin : g_bad_loop_from
    $error("LOOP_FROM out of range");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t        state, nxt_state;
  logic [IW-1:0] idx, nxt_idx;
  logic [15:0]   gap_cnt;
  logic          wdog_expired;

`ifdef SPI_STAGE_SEQ_WATCHDOG_EN
  localparam int          WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WD_MAX  = {WW{1'b1}};

  logic [WW-1:0] wdog_cnt;

  // Counts RUN cycles of the current stage; saturates rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wdog_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (wdog_cnt != WD_MAX) wdog_cnt <= wdog_cnt + 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

  assign wdog_expired = (wdog_cnt >= WD_LAST);
  assign o_err        = (state == ST_ERR);
`else
  assign wdog_expired = 1'b0;
  assign o_err        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= ST_START;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= nxt_state;
      idx     <= nxt_idx;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_idx       = idx;
    o_stage_start = '0;
    o_mosi        = 1'b0;
    o_dc          = 1'b0;
    o_cs          = 1'b1;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (state)
      ST_START: begin
        o_busy    = 1'b1;
        // The pulse is gated by reset so it only appears once reset is released.
        if (i_rst) o_stage_start = START_ONE << idx;
        nxt_state = ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        o_mosi = i_stage_mosi[idx];
        o_dc   = i_stage_dc[idx];
        o_cs   = i_stage_cs[idx];
        if (i_stage_done[idx]) begin
          if (idx != LAST_IDX) begin
            nxt_idx   = idx + 1'b1;
            nxt_state = AFTER_RUN;
          end else if (LOOP != 0) begin
            nxt_idx   = LOOP_IDX;
            nxt_state = AFTER_RUN;
          end else begin
            nxt_state = ST_FIN;
          end
        end else if (wdog_expired) begin
          nxt_state = ST_ERR;
        end
      end
      ST_GAP: begin
        o_busy = 1'b1;
        if (gap_cnt == GAP_LAST) nxt_state = ST_START;
      end
      ST_FIN: begin
        o_done = 1'b1;
        if (i_trig && LOOP == 0) begin
          nxt_idx   = LOOP_IDX;
          nxt_state = ST_START;
        end
      end
      ST_ERR: begin
        // A failed init stage leaves the panel unusable, so only reset recovers it.
        if (i_trig && idx != '0) begin
          nxt_idx   = LOOP_IDX;
          nxt_state = ST_START;
        end
      end
      default: nxt_state = ST_START;
    endcase
  end

  assign o_stage = idx;

endmodule

// File: tb/tb_spi_stage_seq.sv
// Bench for spi_stage_seq: instance 0 runs LOOP=0, instance 1 runs LOOP=1; start pulses go through a scoreboard.
module tb_spi_stage_seq;

  typedef struct packed {
    int stg;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q [2][$];

  logic       rst        [2];
  logic       trig       [2];
  logic [2:0] st_mosi    [2];
  logic [2:0] st_dc      [2];
  logic [2:0] st_cs      [2];
  logic [2:0] mdl_done   [2];
  logic [2:0] extra_done [2];
  logic [2:0] done_in    [2];
  logic [2:0] stall      [2];
  logic [2:0] st_start   [2];
  logic [1:0] stage_w    [2];
  logic       mosi_w     [2];
  logic       dc_w       [2];
  logic       cs_w       [2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic       err_w      [2];
  int         dly        [2];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int s, input int c);
    exp_t e;
    e.stg = s;
    e.cyc = c;
    q[d].push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    assign done_in[d] = mdl_done[d] | extra_done[d];

    spi_stage_seq #(
      .N_STAGES (3),
      .START_GAP(4),
      .LOOP     (d),
      .LOOP_FROM(1),
      .TIMEOUT  (50)
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst[d]),
      .i_trig       (trig[d]),
      .i_stage_mosi (st_mosi[d]),
      .i_stage_dc   (st_dc[d]),
      .i_stage_cs   (st_cs[d]),
      .i_stage_done (done_in[d]),
      .o_stage_start(st_start[d]),
      .o_mosi       (mosi_w[d]),
      .o_dc         (dc_w[d]),
      .o_cs         (cs_w[d]),
      .o_stage      (stage_w[d]),
      .o_busy       (busy_w[d]),
      .o_done       (done_w[d]),
      .o_err        (err_w[d])
    );

    // Stage engines: active after their start pulse, done dly cycles later unless stalled.
    initial begin : model
      int cnt [3];
      bit act [3];
      for (int k = 0; k < 3; k++) begin
        cnt[k] = 0;
        act[k] = 1'b0;
      end
      mdl_done[d] = 3'b000;
      st_cs[d]    = 3'b111;
      st_mosi[d]  = 3'b111;
      st_dc[d]    = 3'b111;
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          mdl_done[d][k] = 1'b0;
          if (!rst[d]) begin
            act[k] = 1'b0;
          end else if (st_start[d][k]) begin
            act[k] = 1'b1;
            cnt[k] = 0;
          end else if (act[k]) begin
            cnt[k]++;
            if (cnt[k] == dly[d] && !stall[d][k]) begin
              mdl_done[d][k] = 1'b1;
              act[k] = 1'b0;
            end
          end
          st_cs[d][k]   = ~act[k];
          st_mosi[d][k] = act[k] ? cnt[k][0] : 1'b1;
          st_dc[d][k]   = act[k] ? cnt[k][1] : 1'b1;
        end
      end
    end

    initial begin : monitor
      exp_t e;
      forever begin
        @(negedge clk);
        if (st_start[d] != 3'b000) begin
          if (q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start dut%0d: got %b required no pulse (cycle %0d)", d, st_start[d], cyc);
          end else begin
            e = q[d].pop_front();
            chk($sformatf("start_vec_dut%0d", d), int'(st_start[d]), 1 << e.stg);
            chk($sformatf("start_cyc_dut%0d", d), cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int b, t, b2, s;
`ifdef SPI_STAGE_SEQ_WATCHDOG_EN
    int t2;
`endif
    for (int d = 0; d < 2; d++) begin
      rst[d]        = 1'b0;
      trig[d]       = 1'b0;
      extra_done[d] = 3'b000;
      stall[d]      = 3'b000;
      dly[d]        = 10;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_w[0], 1);
    chk("rst_cs", cs_w[0], 1);
    chk("rst_start", int'(st_start[0]), 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_err", err_w[0], 0);
    chk("rst_stage", int'(stage_w[0]), 0);
    chk("rst_mosi", mosi_w[0], 0);
    chk("rst_dc", dc_w[0], 0);

    @(posedge clk);
    #1;
    b = cyc;
    push(0, 0, b); push(0, 1, b + 15); push(0, 2, b + 30);
    push(1, 0, b); push(1, 1, b + 15); push(1, 2, b + 30);
    push(1, 1, b + 45); push(1, 2, b + 60); push(1, 1, b + 75);
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    wait_to(b + 6);
    chk("run0_cs", cs_w[0], 0);
    chk("run0_mosi", mosi_w[0], 0);
    chk("run0_dc", dc_w[0], 1);
    chk("run0_stage", int'(stage_w[0]), 0);
    wait_to(b + 12);
    chk("gap_cs", cs_w[0], 1);
    chk("gap_mosi", mosi_w[0], 0);
    chk("gap_dc", dc_w[0], 0);
    chk("gap_stage", int'(stage_w[0]), 1);
    chk("gap_busy", busy_w[0], 1);
    wait_to(b + 20);
    chk("run1_cs", cs_w[0], 0);
    chk("run1_mosi", mosi_w[0], 1);
    chk("run1_dc", dc_w[0], 0);
    wait_to(b + 43);
    chk("fin_done", done_w[0], 1);
    chk("fin_stage", int'(stage_w[0]), 2);
    chk("fin_busy", busy_w[0], 0);
    chk("fin_cs", cs_w[0], 1);
    chk("loop_done_a", done_w[1], 0);
    chk("loop_busy_a", busy_w[1], 1);
    wait_to(b + 80);
    chk("loop_done_b", done_w[1], 0);
    chk("loop_busy_b", busy_w[1], 1);
    chk("loop_stage_b", int'(stage_w[1]), 1);
    wait_to(b + 85);
    rst[1] = 1'b0;

    t = b + 90;
    wait_to(t);
    push(0, 1, t + 1);
    push(0, 2, t + 16);
    trig[0] = 1'b1;
    wait_to(t + 1);
    trig[0] = 1'b0;
    wait_to(t + 5);
    extra_done[0] = 3'b100;
    wait_to(t + 6);
    extra_done[0] = 3'b000;

    wait_to(t + 20);
    chk("pre_rst_cs", cs_w[0], 0);
    chk("pre_rst_stage", int'(stage_w[0]), 2);
    #2;
    rst[0] = 1'b0;
    #1;
    chk("async_rst_cs", cs_w[0], 1);
    chk("async_rst_start", int'(st_start[0]), 0);
    chk("async_rst_stage", int'(stage_w[0]), 0);
    chk("async_rst_busy", busy_w[0], 1);
    chk("async_rst_mosi", mosi_w[0], 0);

    wait_to(t + 23);
    @(posedge clk);
    #1;
    b2 = cyc;
    push(0, 0, b2);
    push(0, 1, b2 + 15);
    stall[0] = 3'b010;
    rst[0]   = 1'b1;

    s = b2 + 15;
    wait_to(s + 50);
    chk("wd_pre_err", err_w[0], 0);
    chk("wd_pre_busy", busy_w[0], 1);
    wait_to(s + 51);
`ifdef SPI_STAGE_SEQ_WATCHDOG_EN
    chk("wd_err", err_w[0], 1);
    chk("wd_cs", cs_w[0], 1);
    chk("wd_stage", int'(stage_w[0]), 1);
    chk("wd_busy", busy_w[0], 0);
    t2 = s + 53;
    wait_to(t2);
    push(0, 1, t2 + 1);
    push(0, 2, t2 + 56);
    stall[0] = 3'b000;
    dly[0]   = 50;
    trig[0]  = 1'b1;
    wait_to(t2 + 1);
    trig[0]  = 1'b0;
    wait_to(t2 + 52);
    chk("wd_edge_err", err_w[0], 0);
    chk("wd_edge_stage", int'(stage_w[0]), 2);
    chk("wd_edge_busy", busy_w[0], 1);
    wait_to(t2 + 60);
`else
    chk("nowd_err", err_w[0], 0);
    chk("nowd_busy", busy_w[0], 1);
    chk("nowd_cs", cs_w[0], 0);
    chk("nowd_stage", int'(stage_w[0]), 1);
    wait_to(s + 60);
`endif

    chk("sb_empty_dut0", q[0].size(), 0);
    chk("sb_empty_dut1", q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_stage_seq.md
SPI_STAGE_SEQ -- requirements
Module: spi_stage_seq

Interface
REQ-001 Parameter N_STAGES, 3: number of sequenced SPI engines (2..8); stage 0 is the panel init engine.
REQ-002 Parameter START_GAP, 16: idle cycles between stages, with CS high (0..65535).
REQ-003 Parameter LOOP, 0: 1 means auto-restart from LOOP_FROM after the last stage.
REQ-004 Parameter LOOP_FROM, 1: restart stage index (1..N_STAGES-1); init is never re-run except by reset.
REQ-005 Parameter TIMEOUT, 27_000_000: watchdog cycles per stage.
REQ-006 Define IW = max(1, clog2(N_STAGES)).
REQ-007 i_clk  in  1  system clock; also the SPI clock.
REQ-008 i_rst  in  1  asynchronous, active-low reset (the board button).
REQ-009 i_trig  in  1  level, sampled; restarts from LOOP_FROM when in FIN or ERR.
REQ-010 i_stage_mosi  in  N_STAGES  per-stage MOSI; bit k belongs to stage k.
REQ-011 i_stage_dc  in  N_STAGES  per-stage D/C.
REQ-012 i_stage_cs  in  N_STAGES  per-stage CS, active-low.
REQ-013 i_stage_done  in  N_STAGES  per-stage done, qualified only in RUN.
REQ-014 o_stage_start  out  N_STAGES  one-cycle start pulse per stage.
REQ-015 o_mosi / o_dc / o_cs  out  1 each  muxed panel SPI lines.
REQ-016 o_stage  out  IW  index of the current stage.
REQ-017 o_busy  out  1  high in START, RUN and GAP.
REQ-018 o_done  out  1  high in FIN.
REQ-019 o_err  out  1  high in ERR.

Function
REQ-020 States: START, RUN, GAP, FIN, ERR; registers state, idx, gap counter and watchdog counter.
REQ-021 START: o_stage_start[idx]=1 combinationally for exactly one cycle, all other start bits 0; next state is RUN, and the watchdog clears.
REQ-022 RUN: o_mosi/o_dc/o_cs = i_stage_*[idx], combinational with no added latency; in all other states mosi=0, dc=0, cs=1.
REQ-023 RUN, i_stage_done[idx]=1 and idx<N_STAGES-1: idx increments; next state is GAP, or START if START_GAP=0.
REQ-024 RUN, i_stage_done[idx]=1 and idx=N_STAGES-1: if LOOP=1, idx becomes LOOP_FROM and the next state is GAP (or START if START_GAP=0); otherwise the next state is FIN.
REQ-025 Done bits of non-selected stages are ignored in all states; done[idx] in START is ignored.
REQ-026 GAP: lasts exactly START_GAP cycles, then START.
REQ-027 FIN: on i_trig=1 (LOOP=0 only), idx becomes LOOP_FROM and the next state is START; with LOOP=1, FIN is unreachable and i_trig is ignored.
REQ-028 ERR: outputs are idle (cs=1) and idx holds the failing stage; i_trig=1 gives idx=LOOP_FROM and the next state is START, unless the failing stage is 0, in which case ERR exits only on reset.
REQ-029 i_trig in START/RUN/GAP has no effect.
REQ-030 The watchdog counts RUN cycles and saturates; reaching TIMEOUT without done gives ERR; done and timeout in the same cycle means done wins.

Reset
REQ-031 While i_rst=0: state=START, idx=0, counters=0, o_stage=0, o_busy=1, o_done=0, o_err=0, o_cs=1, o_mosi=0, o_dc=0, o_stage_start=0 (the pulse is masked during reset).
REQ-032 After reset release, the first rising edge of i_clk leaves START, so the start[0] pulse is the single cycle between release and that edge.
REQ-033 Reset mid-operation aborts immediately; CS goes high asynchronously.

Configuration
REQ-034 With SPI_STAGE_SEQ_WATCHDOG_EN defined, REQ-030 applies and ERR is reachable.
REQ-035 Without SPI_STAGE_SEQ_WATCHDOG_EN, the watchdog counter is absent, o_err is tied 0, ERR is unreachable, and RUN waits indefinitely.

Verification
REQ-036 N_STAGES=3, START_GAP=4, LOOP=0; release reset; each stage asserts done 10 cycles after its start. Required: start pulses at cycles 0, 15 and 30 (±1 per the REQ-032 alignment), then o_done=1 and o_stage=2.
REQ-037 FIN, then one-cycle i_trig. Required: one start[1] pulse, then start[2]; start[0] never pulses again.
REQ-038 LOOP=1, LOOP_FROM=1. Required: the sequence is 0,1,2,1,2,...; o_done stays 0 and o_busy stays 1.
REQ-039 TIMEOUT=50 (macro defined), stage 1 never asserts done. Required: o_err=1 on the 51st RUN cycle, o_cs=1, o_stage=1; i_trig restarts at stage 1. Done on cycle 50 instead gives no error.
REQ-040 Assert i_rst=0 mid-RUN of stage 2 with cs=0. Required: o_cs=1 in the same cycle; after release, stage 0 restarts. Also: stray done[2] during stage 1 is ignored.
